// File: rtl/ntt_sdf_stage_ctrl_if.sv
// Control bundle between one SDF NTT stage controller and its datapath.
// master = controller side, slave = datapath / upstream side.
interface ntt_sdf_stage_ctrl_if #(
  parameter int unsigned LOGN = 3
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            fifo_push;
  logic            fifo_pop;
  logic            sel_fb;
  logic            sel_out;
  logic            bf_enable;
  logic [LOGN-1:0] tw_addr;
  logic            out_valid;
  logic            out_last;
  logic            busy;

  modport master (
    input  in_valid, flush,
    output in_ready, fifo_push, fifo_pop, sel_fb, sel_out, bf_enable,
    output tw_addr, out_valid, out_last, busy
  );

  modport slave (
    output in_valid, flush,
    input  in_ready, fifo_push, fifo_pop, sel_fb, sel_out, bf_enable,
    input  tw_addr, out_valid, out_last, busy
  );
endinterface

// File: rtl/ntt_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF NTT stage: FILL/BFLY phase tracking over N-point
// frames, feedback FIFO/mux/butterfly strobes, twiddle addressing and final drain.
module ntt_sdf_stage_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned STAGE = 0,
  parameter int unsigned LOGN  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  ntt_sdf_stage_ctrl_if.master ctrl
);
  localparam int unsigned D    = N >> (STAGE + 1);
  localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(D - 1);

  typedef enum logic [1:0] {StFill, StBfly, StDrain} phase_e;

  phase_e          phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;

  logic            cnt_last;
  logic [LOGN-1:0] tw_cnt;

  logic            in_ready, fifo_push, fifo_pop, sel_fb, sel_out, bf_enable;
  logic            out_valid, out_last, busy;
  logic [LOGN-1:0] tw_addr;

  assign cnt_last = (cnt_q == CntMax);
  // cnt < D, so the shifted index stays below N/2 and never wraps.
  assign tw_cnt   = LOGN'(cnt_q) << STAGE;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= StFill;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    in_ready  = 1'b1;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    sel_fb    = 1'b0;
    sel_out   = 1'b0;
    bf_enable = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    tw_addr   = '0;
    busy      = pending_q | (cnt_q != '0) | (phase_q != StFill);

    unique case (phase_q)
      StFill: begin
        if (ctrl.in_valid) begin
          // Store the new first operand while emitting the previous frame's difference.
          fifo_push = 1'b1;
          fifo_pop  = pending_q;
          out_valid = pending_q;
          out_last  = pending_q & cnt_last;
          tw_addr   = tw_cnt;
          if (cnt_last) begin
            cnt_d     = '0;
            phase_d   = StBfly;
            pending_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (ctrl.flush && pending_q && (cnt_q == '0)) begin
          phase_d = StDrain;
        end
      end
      StBfly: begin
        if (ctrl.in_valid) begin
          fifo_push = 1'b1;
          fifo_pop  = 1'b1;
          sel_fb    = 1'b1;
          sel_out   = 1'b1;
          bf_enable = 1'b1;
          out_valid = 1'b1;
          if (cnt_last) begin
            cnt_d     = '0;
            phase_d   = StFill;
            pending_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        in_ready  = 1'b0;
        fifo_pop  = 1'b1;
        out_valid = 1'b1;
        out_last  = cnt_last;
        tw_addr   = tw_cnt;
        if (cnt_last) begin
          cnt_d     = '0;
          phase_d   = StFill;
          pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        phase_d = StFill;
        cnt_d   = '0;
      end
    endcase

    // Hold every strobe quiet while reset is asserted, whatever in_valid does.
    if (rst) begin
      in_ready  = 1'b1;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      sel_fb    = 1'b0;
      sel_out   = 1'b0;
      bf_enable = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      tw_addr   = '0;
      busy      = 1'b0;
    end
  end

  assign ctrl.in_ready  = in_ready;
  assign ctrl.fifo_push = fifo_push;
  assign ctrl.fifo_pop  = fifo_pop;
  assign ctrl.sel_fb    = sel_fb;
  assign ctrl.sel_out   = sel_out;
  assign ctrl.bf_enable = bf_enable;
  assign ctrl.tw_addr   = tw_addr;
  assign ctrl.out_valid = out_valid;
  assign ctrl.out_last  = out_last;
  assign ctrl.busy      = busy;
endmodule

// File: tb/tb_ntt_sdf_stage_ctrl.sv
// Directed bench for the SDF stage controller: D=4 (STAGE=0) and D=1 (STAGE=2), N=8.
module tb_ntt_sdf_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_sdf_stage_ctrl_if #(.LOGN(3)) if0 ();
  ntt_sdf_stage_ctrl_if #(.LOGN(3)) if2 ();

  ntt_sdf_stage_ctrl #(.N(8), .STAGE(0), .LOGN(3)) u_dut0 (.clk(clk), .rst(rst), .ctrl(if0));
  ntt_sdf_stage_ctrl #(.N(8), .STAGE(2), .LOGN(3)) u_dut2 (.clk(clk), .rst(rst), .ctrl(if2));

  // Strobe vector order: in_ready push pop sel_fb sel_out bf_enable out_valid out_last busy
  localparam logic [8:0] Idle   = 9'b100000000;
  localparam logic [8:0] Stall  = 9'b100000001;
  localparam logic [8:0] Fill0  = 9'b110000000;
  localparam logic [8:0] FillB  = 9'b110000001;
  localparam logic [8:0] FillP  = 9'b111000101;
  localparam logic [8:0] FillPL = 9'b111000111;
  localparam logic [8:0] Bfly   = 9'b111111101;
  localparam logic [8:0] Drain  = 9'b001000101;
  localparam logic [8:0] DrainL = 9'b001000111;

  logic [8:0] obs0, obs2;
  assign obs0 = {if0.in_ready, if0.fifo_push, if0.fifo_pop, if0.sel_fb, if0.sel_out,
                 if0.bf_enable, if0.out_valid, if0.out_last, if0.busy};
  assign obs2 = {if2.in_ready, if2.fifo_push, if2.fifo_pop, if2.sel_fb, if2.sel_out,
                 if2.bf_enable, if2.out_valid, if2.out_last, if2.busy};

  int n_checks = 0;
  int n_errors = 0;
  int ov_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the selected instance, check at the falling edge, then advance.
  task automatic step(input logic r, input int sel, input logic iv, input logic fl,
                      input logic [8:0] ev, input logic [2:0] etw, input string tag);
    rst          = r;
    if0.in_valid = (sel == 0) ? iv : 1'b0;
    if0.flush    = (sel == 0) ? fl : 1'b0;
    if2.in_valid = (sel == 2) ? iv : 1'b0;
    if2.flush    = (sel == 2) ? fl : 1'b0;
    @(negedge clk);
    if (sel == 0) begin
      check_eq({tag, "/strb"}, 32'(obs0), 32'(ev));
      check_eq({tag, "/tw"}, 32'(if0.tw_addr), 32'(etw));
      ov_cnt += int'(if0.out_valid);
    end else begin
      check_eq({tag, "/strb"}, 32'(obs2), 32'(ev));
      check_eq({tag, "/tw"}, 32'(if2.tw_addr), 32'(etw));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    if0.in_valid = 1'b1;
    if0.flush    = 1'b0;
    if2.in_valid = 1'b1;
    if2.flush    = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 1'b0, Idle, 3'd0, "rst");

    // Single frame, inputs 1..8, then flush drain
    step(1'b0, 0, 1'b1, 1'b0, Fill0, 3'd0, "f1_fill0");
    for (int i = 1; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, FillB, 3'(i), "f1_fill");
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "f1_bfly");
    step(1'b0, 0, 1'b0, 1'b1, Stall, 3'd0, "f1_drain_entry");
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1, Drain, 3'(i), "f1_drain");
    step(1'b0, 0, 1'b0, 1'b1, DrainL, 3'd3, "f1_drain_last");
    step(1'b0, 0, 1'b0, 1'b0, Idle, 3'd0, "f1_idle");
    check_eq("f1_out_count", 32'(ov_cnt), 32'd8);

    // Two back-to-back frames with a 2-cycle stall at BFLY cnt=2
    ov_cnt = 0;
    step(1'b0, 0, 1'b1, 1'b0, Fill0, 3'd0, "b2b_fill0");
    for (int i = 1; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, FillB, 3'(i), "b2b_fill");
    step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "b2b_bfly0");
    step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "b2b_bfly1");
    step(1'b0, 0, 1'b0, 1'b0, Stall, 3'd0, "b2b_stall");
    step(1'b0, 0, 1'b0, 1'b0, Stall, 3'd0, "b2b_stall");
    step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "b2b_bfly2");
    step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "b2b_bfly3");
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, FillP, 3'(i), "b2b_f2_fill");
    step(1'b0, 0, 1'b1, 1'b0, FillPL, 3'd3, "b2b_f2_fill_last");
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "b2b_f2_bfly");
    check_eq("b2b_out_count_pre_drain", 32'(ov_cnt), 32'd12);
    step(1'b0, 0, 1'b0, 1'b1, Stall, 3'd0, "b2b_drain_entry");
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1, Drain, 3'(i), "b2b_drain");
    step(1'b0, 0, 1'b0, 1'b1, DrainL, 3'd3, "b2b_drain_last");
    step(1'b0, 0, 1'b0, 1'b0, Idle, 3'd0, "b2b_idle");
    check_eq("b2b_out_count", 32'(ov_cnt), 32'd16);

    // Reset mid-BFLY at cnt=1 discards state
    step(1'b0, 0, 1'b1, 1'b0, Fill0, 3'd0, "mr_fill0");
    for (int i = 1; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, FillB, 3'(i), "mr_fill");
    step(1'b0, 0, 1'b1, 1'b0, Bfly, 3'd0, "mr_bfly0");
    step(1'b1, 0, 1'b1, 1'b0, Idle, 3'd0, "mr_rst");
    step(1'b0, 0, 1'b0, 1'b0, Idle, 3'd0, "mr_after");
    step(1'b0, 0, 1'b1, 1'b0, Fill0, 3'd0, "mr_restart");
    step(1'b1, 0, 1'b0, 1'b0, Idle, 3'd0, "mr_rst2");

    // D=1: phase flips every sample, tw_addr stays 0, in_valid ignored in DRAIN
    step(1'b0, 2, 1'b1, 1'b0, Fill0, 3'd0, "d1_fill_a");
    step(1'b0, 2, 1'b1, 1'b0, Bfly, 3'd0, "d1_bfly_a");
    step(1'b0, 2, 1'b1, 1'b0, FillPL, 3'd0, "d1_fill_b");
    step(1'b0, 2, 1'b1, 1'b0, Bfly, 3'd0, "d1_bfly_b");
    step(1'b0, 2, 1'b0, 1'b1, Stall, 3'd0, "d1_drain_entry");
    step(1'b0, 2, 1'b1, 1'b0, DrainL, 3'd0, "d1_drain");
    step(1'b0, 2, 1'b0, 1'b0, Idle, 3'd0, "d1_idle");
    step(1'b0, 2, 1'b1, 1'b0, Fill0, 3'd0, "d1_fill_c");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
